data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory behind a valid/ready request
// interface. Each accepted request waits WAIT_CYCLES cycles, performs one
// read or write, then issues a one-cycle response strobe.
// Optional build macro: DMR_ERR_CHECK_EN (adds alignment and range checks on
// the byte address; when undefined the word index wraps modulo DEPTH).
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_DMR,
  input  logic        rst_DMR,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] memAddr,
  input  logic [31:0] memData,
  input  logic        memReadFlag,
  input  logic        memWriteFlag,
  output logic        respValid,
  output logic [31:0] data,
  output logic        errFlag
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_next_s;

  // captured request
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic          rd_r;
  logic          wr_r;
  logic          capture_s;

  // operands of the access performed this edge (live inputs when the access
  // happens on the accept edge, captured copies otherwise)
  logic          access_s;
  logic [31:0]   acc_addr_s;
  logic [31:0]   acc_wdata_s;
  logic          acc_rd_s;
  logic          acc_wr_s;

  logic [29:0]   word_s;
  logic [AW-1:0] idx_s;
  logic          addr_err_s;
  logic          req_err_s;
  logic          do_read_s;
  logic          do_write_s;

  logic          resp_valid_r;
  logic [31:0]   data_r;
  logic          err_r;

  // Power-up contents are all zeros; no reset touches the array so contents
  // survive rst_DMR.
  logic [31:0]   mem_r [DEPTH] = '{default: 32'h0000_0000};

  // Next-state, counter and access-operand selection.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    access_s     = 1'b0;
    acc_addr_s   = addr_r;
    acc_wdata_s  = wdata_r;
    acc_rd_s     = rd_r;
    acc_wr_s     = wr_r;
    case (state_r)
      IDLE: begin
        if (reqValid) begin
          capture_s   = 1'b1;
          acc_addr_s  = memAddr;
          acc_wdata_s = memData;
          acc_rd_s    = memReadFlag;
          acc_wr_s    = memWriteFlag;
          if (WAIT_CYCLES == 0) begin
            access_s     = 1'b1;
            next_state_s = RESP;
            cnt_next_s   = 4'd0;
          end else begin
            next_state_s = WAIT;
            cnt_next_s   = 4'(WAIT_CYCLES);
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          access_s     = 1'b1;
          next_state_s = RESP;
          cnt_next_s   = 4'd0;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Request decode: word index, error conditions and access enables.
  always_comb begin
    word_s = acc_addr_s[31:2];
    idx_s  = AW'(word_s % 30'(DEPTH));
`ifdef DMR_ERR_CHECK_EN
    addr_err_s = (acc_addr_s[1:0] != 2'b00) || (word_s >= 30'(DEPTH));
`else
    addr_err_s = 1'b0;
`endif
    req_err_s  = (acc_rd_s == acc_wr_s) || addr_err_s;
    do_read_s  = access_s && acc_rd_s && !req_err_s;
    do_write_s = access_s && acc_wr_s && !req_err_s;
  end

`ifndef DMR_ERR_CHECK_EN
  // byte-offset bits are deliberately ignored in the wrapping build
  logic unused_offset_s;
  assign unused_offset_s = ^acc_addr_s[1:0];
`endif

  // FSM state and wait counter.
  always_ff @(posedge clk_DMR) begin
    if (rst_DMR) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Capture the request on the accept edge.
  always_ff @(posedge clk_DMR) begin
    if (rst_DMR) begin
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else if (capture_s) begin
      addr_r  <= memAddr;
      wdata_r <= memData;
      rd_r    <= memReadFlag;
      wr_r    <= memWriteFlag;
    end
  end

  // Response registers: loaded on the access edge, cleared on every other edge.
  always_ff @(posedge clk_DMR) begin
    if (rst_DMR) begin
      resp_valid_r <= 1'b0;
      data_r       <= 32'h0000_0000;
      err_r        <= 1'b0;
    end else begin
      resp_valid_r <= access_s;
      err_r        <= access_s && req_err_s;
      data_r       <= do_read_s ? mem_r[idx_s] : 32'h0000_0000;
    end
  end

  // Memory write; a reset on the access edge suppresses it.
  always_ff @(posedge clk_DMR) begin
    if (!rst_DMR && do_write_s) begin
      mem_r[idx_s] <= acc_wdata_s;
    end
  end

  // Ready is held low while reset is asserted.
  assign reqReady  = (state_r == IDLE) && !rst_DMR;
  assign respValid = resp_valid_r;
  assign data      = data_r;
  assign errFlag   = err_r;

endmodule
